// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//
// Assembles framed command packets from the byte stream of a UART receiver.
// Frame layout: SYNC, robot ID, LEN, LEN payload bytes, [XOR checksum].
// A validated frame is held in the payload buffer and offered to the command
// decoder through a level pkt_ready / pkt_ack handshake plus a random-access
// combinational read port.
//
// Compile-time feature macro: PKT_CHECKSUM_EN
//   defined   : frame carries a trailing XOR checksum (ID ^ LEN ^ payload),
//               S_CHK is present and err_chk is live.
//   undefined : no checksum byte, frame completes on its last payload byte,
//               err_chk is tied to 0.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   data_flag    byte valid from the receiver (may stay high several cycles)
//   data_byte    received byte, stable while data_flag is high
//   pkt_ready    a validated frame is held
//   pkt_id       robot ID of the held frame
//   pkt_len      payload length of the held frame
//   rd_addr      payload read index
//   rd_data      buffer[rd_addr], combinational
//   pkt_ack      consumer releases the held frame
//   err_chk      1-cycle pulse: checksum mismatch
//   err_len      1-cycle pulse: LEN is 0 or above MAX_LEN
//   err_timeout  1-cycle pulse: inter-byte timeout inside a frame
//   err_overrun  1-cycle pulse: SYNC while a frame is still held
// -----------------------------------------------------------------------------
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [7:0]  MAX_LEN      = 8'd8,     // legal range 1..15
    parameter logic [15:0] TIMEOUT_CLKS = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_flag,
    input  logic [7:0] data_byte,
    output logic       pkt_ready,
    output logic [7:0] pkt_id,
    output logic [3:0] pkt_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       pkt_ack,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_LEN,
        S_PAYLOAD
`ifdef PKT_CHECKSUM_EN
        , S_CHK
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        flag_q;
    logic [7:0]  id_q, id_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] tmo_q, tmo_d;
    logic        ready_q, ready_d;
    logic [7:0]  pkt_id_q, pkt_id_d;
    logic [3:0]  pkt_len_q, pkt_len_d;
    logic        err_len_q, err_len_d;
    logic        err_tmo_q, err_tmo_d;
    logic        err_ovr_q, err_ovr_d;
    logic        accept;
    logic        wr_en;
    logic        complete;
    logic [7:0]  buf_q [16];
`ifdef PKT_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
    logic        err_chk_q, err_chk_d;
`endif

    // Rising edge of data_flag: a flag held high for several cycles yields
    // exactly one accept. flag_q resets high so a flag already asserted at
    // reset release is not taken as a new byte.
    assign accept = data_flag & ~flag_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips an assignment infers a latch.
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tmo_d     = 16'd0;
        ready_d   = ready_q;
        pkt_id_d  = pkt_id_q;
        pkt_len_d = pkt_len_q;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;
        wr_en     = 1'b0;
        complete  = 1'b0;
`ifdef PKT_CHECKSUM_EN
        chk_d     = chk_q;
        err_chk_d = 1'b0;
`endif

        if (ready_q && pkt_ack) begin
            ready_d = 1'b0;
        end

        // Inter-byte timer runs only while a frame is in progress.
        if (state_q != S_IDLE) begin
            tmo_d = accept ? 16'd0 : tmo_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && data_byte == SYNC_BYTE) begin
                    // An ack in the same cycle frees the buffer, so the new
                    // frame may start instead of flagging an overrun.
                    if (ready_q && !pkt_ack) begin
                        err_ovr_d = 1'b1;
                    end else begin
                        state_d = S_ID;
`ifdef PKT_CHECKSUM_EN
                        chk_d   = 8'h00;
`endif
                    end
                end
            end
            S_ID: begin
                if (accept) begin
                    id_d    = data_byte;
                    state_d = S_LEN;
`ifdef PKT_CHECKSUM_EN
                    chk_d   = chk_q ^ data_byte;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (data_byte == 8'd0 || data_byte > MAX_LEN) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = data_byte[3:0];
                        idx_d   = 4'd0;
                        state_d = S_PAYLOAD;
`ifdef PKT_CHECKSUM_EN
                        chk_d   = chk_q ^ data_byte;
`endif
                    end
                end
            end
            S_PAYLOAD: begin
                // SYNC_BYTE is ordinary data here; no resync inside a frame.
                if (accept) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 4'd1;
`ifdef PKT_CHECKSUM_EN
                    chk_d = chk_q ^ data_byte;
                    if (idx_q == len_q - 4'd1) begin
                        state_d = S_CHK;
                    end
`else
                    if (idx_q == len_q - 4'd1) begin
                        complete = 1'b1;
                    end
`endif
                end
            end
`ifdef PKT_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (data_byte == chk_q) begin
                        complete = 1'b1;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            ready_d   = 1'b1;
            pkt_id_d  = id_q;
            pkt_len_d = len_q;
            state_d   = S_IDLE;
        end

        // An accept in the same cycle restarts the timer instead.
        if (state_q != S_IDLE && !accept && tmo_q == TIMEOUT_CLKS - 16'd1) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
            tmo_d     = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            flag_q    <= 1'b1;
            id_q      <= 8'h00;
            len_q     <= 4'd0;
            idx_q     <= 4'd0;
            tmo_q     <= 16'd0;
            ready_q   <= 1'b0;
            pkt_id_q  <= 8'h00;
            pkt_len_q <= 4'd0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flag_q    <= data_flag;
            id_q      <= id_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            ready_q   <= ready_d;
            pkt_id_q  <= pkt_id_d;
            pkt_len_q <= pkt_len_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
            err_ovr_q <= err_ovr_d;
        end
    end

`ifdef PKT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q     <= 8'h00;
            err_chk_q <= 1'b0;
        end else begin
            chk_q     <= chk_d;
            err_chk_q <= err_chk_d;
        end
    end
    assign err_chk = err_chk_q;
`else
    assign err_chk = 1'b0;
`endif

    // NOTE: the payload buffer is deliberately not reset; its contents are
    // only meaningful while pkt_ready is high, and leaving it out of reset
    // keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[idx_q] <= data_byte;
        end
    end

    assign rd_data     = buf_q[rd_addr];
    assign pkt_ready   = ready_q;
    assign pkt_id      = pkt_id_q;
    assign pkt_len     = pkt_len_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// Testbench for uart_frame_parser. Expected frame/error events are queued as
// stimulus is driven; a negedge monitor pops one entry per observed event.
// Works with and without PKT_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

    localparam logic [7:0] SYNC = 8'hA5;
`ifdef PKT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum int {EV_FRAME, EV_CHK, EV_LEN, EV_TMO, EV_OVR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] id;
        logic [3:0] len;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_flag;
    logic [7:0] data_byte;
    logic       pkt_ready;
    logic [7:0] pkt_id;
    logic [3:0] pkt_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       pkt_ack;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;

    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  exp_q[$];
    logic ready_prev = 1'b0;

    uart_frame_parser dut (
        .clk         (clk),
        .rst         (rst),
        .data_flag   (data_flag),
        .data_byte   (data_byte),
        .pkt_ready   (pkt_ready),
        .pkt_id      (pkt_id),
        .pkt_len     (pkt_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pkt_ack     (pkt_ack),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic observe(input ev_kind_e kind);
        ev_t e;
        check("event_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_FRAME && e.kind == EV_FRAME) begin
                check("pkt_id", 32'(pkt_id), 32'(e.id));
                check("pkt_len", 32'(pkt_len), 32'(e.len));
            end
        end
    endtask

    // Each cycle an error output is high counts as one event, so a pulse
    // wider than one cycle shows up as an unexpected extra event.
    always @(negedge clk) begin
        if (pkt_ready === 1'b1 && ready_prev !== 1'b1) observe(EV_FRAME);
        if (err_chk === 1'b1)     observe(EV_CHK);
        if (err_len === 1'b1)     observe(EV_LEN);
        if (err_timeout === 1'b1) observe(EV_TMO);
        if (err_overrun === 1'b1) observe(EV_OVR);
        ready_prev <= pkt_ready;
    end

    function automatic void push_ev(input ev_kind_e kind, input logic [7:0] id, input logic [3:0] len);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.len  = len;
        exp_q.push_back(e);
    endfunction

    // One byte: flag high for 'hold' cycles, then low for one cycle.
    // exp_ready >= 0 checks pkt_ready in the cycle right after the accept.
    task automatic send_byte(input logic [7:0] b, input int hold, input bit ack, input int exp_ready);
        @(negedge clk);
        data_byte = b;
        data_flag = 1'b1;
        if (ack) pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        if (exp_ready >= 0) check("frame_latency", 32'(pkt_ready), 32'(exp_ready));
        repeat (hold - 1) @(negedge clk);
        data_flag = 1'b0;
        @(negedge clk);
    endtask

    // Payload byte i lives at pay[8*i +: 8].
    task automatic send_frame(input logic [7:0] id, input logic [3:0] len, input logic [127:0] pay,
                              input bit bad, input int hold, input bit ack_on_sync);
`ifdef PKT_CHECKSUM_EN
        logic [7:0] chk;
        chk = id ^ {4'h0, len};
        for (int i = 0; i < int'(len); i++) chk = chk ^ pay[8*i +: 8];
`endif
        push_ev((bad && CHK_EN) ? EV_CHK : EV_FRAME, id, len);
        send_byte(SYNC, hold, ack_on_sync, -1);
        send_byte(id, hold, 1'b0, -1);
        send_byte({4'h0, len}, hold, 1'b0, -1);
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pay[8*i +: 8], hold, 1'b0, (i == int'(len) - 1 && !CHK_EN) ? 1 : -1);
        end
`ifdef PKT_CHECKSUM_EN
        send_byte(chk ^ {7'h00, bad}, hold, 1'b0, bad ? 0 : 1);
`endif
    endtask

    task automatic read_payload(input logic [3:0] len, input logic [127:0] pay);
        for (int i = 0; i < int'(len); i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            #1;
            check("rd_data", 32'(rd_data), 32'(pay[8*i +: 8]));
        end
    endtask

    task automatic release_frame();
        @(negedge clk);
        check("held_before_ack", 32'(pkt_ready), 1);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        check("release_latency", 32'(pkt_ready), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {19'h0, pkt_ready, pkt_id, pkt_len, err_chk, err_len, err_timeout, err_overrun}, 0);
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        data_flag = 1'b0;
        data_byte = 8'h00;
        pkt_ack   = 1'b0;
        rd_addr   = 4'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good frame A5 03 02 11 22 [32]
        send_frame(8'h03, 4'd2, 128'h2211, 1'b0, 1, 1'b0);
        read_payload(4'd2, 128'h2211);
        release_frame();

        // Corrupted checksum A5 03 02 11 22 [33]
        send_frame(8'h03, 4'd2, 128'h2211, 1'b1, 1, 1'b0);
`ifdef PKT_CHECKSUM_EN
        check("bad_chk_not_ready", 32'(pkt_ready), 0);
`else
        release_frame();
`endif

        // Length 0, 16 and MAX_LEN+1 are rejected; MAX_LEN itself is fine.
        push_ev(EV_LEN, 8'h00, 4'd0);
        send_byte(SYNC, 1, 1'b0, -1); send_byte(8'h07, 1, 1'b0, -1); send_byte(8'h00, 1, 1'b0, 0);
        push_ev(EV_LEN, 8'h00, 4'd0);
        send_byte(SYNC, 1, 1'b0, -1); send_byte(8'h07, 1, 1'b0, -1); send_byte(8'h10, 1, 1'b0, 0);
        push_ev(EV_LEN, 8'h00, 4'd0);
        send_byte(SYNC, 1, 1'b0, -1); send_byte(8'h07, 1, 1'b0, -1); send_byte(8'h09, 1, 1'b0, 0);
        send_frame(8'h07, 4'd8, 128'h88_77_66_55_44_33_22_11, 1'b0, 1, 1'b0);
        read_payload(4'd8, 128'h88_77_66_55_44_33_22_11);
        release_frame();

        // Stall after A5 03: timeout about TIMEOUT_CLKS cycles after the last accept.
        push_ev(EV_TMO, 8'h00, 4'd0);
        send_byte(SYNC, 1, 1'b0, -1);
        send_byte(8'h03, 1, 1'b0, -1);
        cnt = 1;
        while (err_timeout !== 1'b1 && cnt < 1200) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_delay_in_window", 32'(cnt >= 995 && cnt <= 1005), 1);

        // Flag stretched to 4 cycles per byte; payload contains the SYNC value.
        send_frame(8'h44, 4'd3, 128'hFF_A5_01, 1'b0, 4, 1'b0);
        read_payload(4'd3, 128'hFF_A5_01);
        release_frame();

        // Overrun while held, data preserved; then ack together with SYNC.
        send_frame(8'h21, 4'd3, 128'h30_20_10, 1'b0, 1, 1'b0);
        push_ev(EV_OVR, 8'h00, 4'd0);
        send_byte(SYNC, 1, 1'b0, -1);
        check("held_after_overrun", 32'(pkt_ready), 1);
        check("id_after_overrun", 32'(pkt_id), 32'h21);
        read_payload(4'd3, 128'h30_20_10);
        send_frame(8'h22, 4'd2, 128'h5A_A5, 1'b0, 1, 1'b1);
        read_payload(4'd2, 128'h5A_A5);
        release_frame();

        // Ack while nothing is held is ignored.
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        check("ack_when_idle", 32'(pkt_ready), 0);

        // Leading noise, then a frame left held across a reset.
        send_byte(8'h00, 1, 1'b0, -1);
        send_byte(8'hFF, 1, 1'b0, -1);
        send_frame(8'h09, 4'd1, 128'h3C, 1'b0, 1, 1'b0);
        read_payload(4'd1, 128'h3C);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_clears_held");
        rst = 1'b0;

        // Reset mid-frame: no pulses even after a timeout's worth of idle.
        send_byte(SYNC, 1, 1'b0, -1);
        send_byte(8'h03, 1, 1'b0, -1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_frame");
        rst = 1'b0;
        repeat (1100) @(negedge clk);
        send_frame(8'h0B, 4'd2, 128'hBE_EF, 1'b0, 1, 1'b0);
        read_payload(4'd2, 128'hBE_EF);
        release_frame();

        repeat (3) @(negedge clk);
        check("events_pending_at_end", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
